// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: shares the single-port Tetris board RAM between the
// display pixel path (priority, fixed latency, no handshake) and the game
// engine (req/gnt handshake). A starvation counter forces a pending game
// request through after STARVE_MAX consecutive display-won cycles.
// Optional macro BOARD_ARB_VBLANK_LOCK_EN: game writes are only granted while
// iVBLANK is high so board updates never tear mid-frame.
module board_ram_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned STARVE_MAX = 64
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              iVBLANK,
  input  logic              disp_rd,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              disp_miss,
  input  logic              g_req,
  input  logic              g_we,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [DATA_W-1:0] g_wdata,
  output logic              g_gnt,
  output logic [DATA_W-1:0] g_rdata,
  output logic              g_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_DISP, S_GAME, S_FORCE} state_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_GAME} tag_e;

  state_e            state_q, state_d;
  tag_e              p1_q, p1_d, p2_q, p2_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              gnt_q, gnt_d;
  logic              miss_q, miss_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              g_rvalid_q, g_rvalid_d;
  logic [DATA_W-1:0] g_rdata_q, g_rdata_d;
  logic              lock_ok_c;
  logic              game_want_c;

`ifdef BOARD_ARB_VBLANK_LOCK_EN
  // Writes wait for vertical blanking; reads are always allowed.
  assign lock_ok_c = g_we ? iVBLANK : 1'b1;
`else
  logic unused_vblank;
  assign unused_vblank = iVBLANK;
  assign lock_ok_c     = 1'b1;
`endif

  // A request is ignored in the cycle its grant is showing (stale request).
  assign game_want_c = g_req && (state_q != S_GAME) && (state_q != S_FORCE) && lock_ok_c;

  // Next-state arbitration, RAM command, response pipe and starvation count.
  always_comb begin
    state_d      = S_IDLE;
    gnt_d        = 1'b0;
    miss_d       = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    p1_d         = TAG_NONE;
    p2_d         = p1_q;
    starve_d     = starve_q;
    disp_valid_d = 1'b0;
    disp_data_d  = disp_data_q;
    g_rvalid_d   = 1'b0;
    g_rdata_d    = g_rdata_q;

    if (game_want_c && !disp_rd) begin
      state_d = S_GAME;
    end else if (game_want_c && disp_rd && (starve_q == CNT_W'(STARVE_MAX))) begin
      state_d = S_FORCE;
    end else if (disp_rd) begin
      state_d = S_DISP;
    end

    case (state_d)
      S_DISP: begin
        mem_addr_d = disp_addr;
        p1_d       = TAG_DISP;
      end
      S_GAME, S_FORCE: begin
        mem_addr_d  = g_addr;
        mem_we_d    = g_we;
        mem_wdata_d = g_wdata;
        gnt_d       = 1'b1;
        miss_d      = (state_d == S_FORCE);
        p1_d        = g_we ? TAG_NONE : TAG_GAME;
      end
      default: ;
    endcase

    // RAM data for an access issued two edges ago is on mem_rdata now.
    if (p2_q == TAG_DISP) begin
      disp_valid_d = 1'b1;
      disp_data_d  = mem_rdata;
    end else if (p2_q == TAG_GAME) begin
      g_rvalid_d = 1'b1;
      g_rdata_d  = mem_rdata;
    end

    if (gnt_d || !g_req) begin
      starve_d = '0;
    end else if ((state_d == S_DISP) && (starve_q != CNT_W'(STARVE_MAX))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // State and output registers; reset discards in-flight responses.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= S_IDLE;
      p1_q         <= TAG_NONE;
      p2_q         <= TAG_NONE;
      starve_q     <= '0;
      gnt_q        <= 1'b0;
      miss_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      g_rvalid_q   <= 1'b0;
      g_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      starve_q     <= starve_d;
      gnt_q        <= gnt_d;
      miss_q       <= miss_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      g_rvalid_q   <= g_rvalid_d;
      g_rdata_q    <= g_rdata_d;
    end
  end

  assign g_gnt      = gnt_q;
  assign disp_miss  = miss_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign g_rvalid   = g_rvalid_q;
  assign g_rdata    = g_rdata_q;

endmodule
